// File: rtl/ctrl_seq_decoder.sv
// rtl/ctrl_seq_decoder.sv - opcode-to-control-word sequencer with repeat count and optional saturation loop
//
// Accepts opcodes on a valid/ready input and emits a one-hot-plus-marker control
// word for R+1 beats on a valid/ready output. R is the repeat count in the upper
// opcode bits.
//
// Optional feature macro: CTRL_SAT_LOOP_EN
//   When defined, select 5'h1F with R==0 enters LOOP. Beats then repeat until a
//   beat sees sat=1 or the iteration cap is reached.
//   When undefined, sat is unused and 5'h1F decodes as a normal instruction.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready/in_op opcode input; in_op[4:0] select, in_op[OPW-1:5] repeat count
//   out_valid/out_ready     control word output handshake
//   out_cw                  decoded control word
//   out_last                final beat of the current instruction
//   out_beat                zero-based beat index within the instruction
//   busy                    sequencer not idle
//   sat                     datapath saturation flag (loop mode only)

module ctrl_seq_decoder #(
    parameter int OPW      = 7,
    parameter int CW       = 26,
    parameter int MAX_ITER = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] in_op,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [CW-1:0]  out_cw,
    output logic           out_last,
    output logic [7:0]     out_beat,
    output logic           busy,
    input  logic           sat
);

    localparam int RW = OPW - 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1
`ifdef CTRL_SAT_LOOP_EN
        ,
        LOOP  = 2'd2
`endif
    } state_t;

    state_t         state_q;
    state_t         state_d;

    // Held low through reset and set by the first clock afterwards, so in_ready
    // stays low while reset is asserted even though the state is IDLE.
    logic           ready_en_q;

    logic [4:0]     sel_q;
    logic [RW-1:0]  rep_q;
    logic [7:0]     beat_q;

    logic           accept;
    logic           out_hs;
    logic           final_hs;
    logic           loop_op;

    assign accept   = in_valid & in_ready;
    assign out_hs   = out_valid & out_ready;
    assign final_hs = out_hs & out_last;

`ifdef CTRL_SAT_LOOP_EN
    localparam logic [7:0] LAST_ITER = 8'(MAX_ITER - 1);

    assign loop_op = (in_op[4:0] == 5'h1F) && (in_op[OPW-1:5] == '0);
`else
    logic unused_sat;

    assign loop_op    = 1'b0;
    assign unused_sat = sat;
`endif

    // Control word: marker bit at the top, plus one bit picked by select
    // folded into the remaining CW-1 positions.
    function automatic logic [CW-1:0] decode_cw(input logic [4:0] sel);
        logic [CW-1:0] w;
        int            idx;
        idx = int'(sel) % (CW - 1);
        w   = '0;
        for (int i = 0; i < CW - 1; i++) begin
            w[i] = (i == idx);
        end
        w[CW-1] = 1'b1;
        return w;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef CTRL_SAT_LOOP_EN
                    state_d = loop_op ? LOOP : ISSUE;
`else
                    state_d = ISSUE;
`endif
                end
            end
            ISSUE: begin
                // A final-beat handshake may chain straight into the next opcode.
                if (final_hs) begin
                    if (accept) begin
`ifdef CTRL_SAT_LOOP_EN
                        state_d = loop_op ? LOOP : ISSUE;
`else
                        state_d = ISSUE;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
`ifdef CTRL_SAT_LOOP_EN
            LOOP: begin
                if (final_hs) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b0;
        out_last  = 1'b0;
        in_ready  = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = ready_en_q;
            end
            ISSUE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_last  = (beat_q == {{(8-RW){1'b0}}, rep_q});
                in_ready  = ready_en_q & out_ready & out_last;
            end
`ifdef CTRL_SAT_LOOP_EN
            LOOP: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_last  = sat | (beat_q == LAST_ITER);
            end
`endif
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    assign out_cw   = out_valid ? decode_cw(sel_q) : '0;
    assign out_beat = beat_q;

    // Opcode and beat-counter datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
            sel_q      <= '0;
            rep_q      <= '0;
            beat_q     <= '0;
        end else begin
            ready_en_q <= 1'b1;
            if (accept) begin
                sel_q  <= in_op[4:0];
                rep_q  <= in_op[OPW-1:5];
                beat_q <= '0;
            end else if (final_hs) begin
                beat_q <= '0;
            end else if (out_hs) begin
                beat_q <= beat_q + 8'd1;
            end
        end
    end

endmodule

// File: doc/ctrl_seq_decoder.md
CTRL_SEQ_DECODER -- requirements
Module: ctrl_seq_decoder

Interface
REQ-001 Parameter OPW, default 7: opcode width, legal 6..12.
REQ-002 Parameter CW, default 26: control-word width, legal 8..64.
REQ-003 Parameter MAX_ITER, default 15: loop-mode iteration cap, legal 1..255.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  in  1  opcode offered.
REQ-007 in_ready  out  1  opcode accepted when in_valid&in_ready.
REQ-008 in_op  in  OPW  opcode; [4:0] select, [OPW-1:5] repeat count R.
REQ-009 out_valid  out  1  control word presented.
REQ-010 out_ready  in  1  consumer takes beat when out_valid&out_ready.
REQ-011 out_cw  out  CW  decoded control word.
REQ-012 out_last  out  1  current beat is final beat of the instruction.
REQ-013 out_beat  out  8  zero-based beat index within instruction.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 sat  in  1  saturation flag from datapath (sampled only with CTRL_SAT_LOOP_EN).

Function
REQ-016 Decode SHALL be out_cw[CW-1]=1 always; out_cw[(in_op[4:0] mod (CW-1))]=1; all other bits 0.
REQ-017 States SHALL be IDLE, ISSUE, and LOOP (LOOP only with CTRL_SAT_LOOP_EN).
REQ-018 in_ready SHALL be 1 in IDLE, and 1 in ISSUE only during the cycle out_last&out_valid&out_ready holds; 0 otherwise.
REQ-019 On acceptance the opcode SHALL be registered; out_valid rises the following cycle (latency 1), out_beat=0.
REQ-020 Normal instruction SHALL issue exactly R+1 beats, out_beat incrementing by 1 per handshaked beat; out_cw identical on every beat.
REQ-021 out_last SHALL be 1 iff out_beat==R.
REQ-022 out_valid, out_cw, out_beat, out_last SHALL hold stable while out_valid&~out_ready (no beat dropped or duplicated).
REQ-023 Final-beat handshake with simultaneous input acceptance SHALL load the new opcode and present its beat 0 next cycle (no bubble); without new input, state returns to IDLE and out_valid drops next cycle.
REQ-024 in_op SHALL be ignored whenever in_ready=0.

Reset
REQ-025 While rst_n=0: state IDLE, out_valid=0, out_cw=0, out_beat=0, out_last=0, busy=0, in_ready=0.
REQ-026 First rising clk with rst_n=1 SHALL show in_ready=1.
REQ-027 Reset mid-instruction SHALL abort it; no remaining beats issued after release.

Configuration
REQ-028 Macro CTRL_SAT_LOOP_EN SHALL add until-saturation mode.
REQ-029 With macro: opcode with in_op[4:0]==5'h1F and R==0 enters LOOP; beats repeat until a handshaked beat samples sat=1 or out_beat==MAX_ITER-1, that beat carrying out_last=1.
REQ-030 In LOOP, out_last SHALL be combinational from sat|(out_beat==MAX_ITER-1); out_cw per REQ-016.
REQ-031 Without macro: LOOP absent, sat unused, 5'h1F decoded as a normal instruction.

Verification
REQ-032 Reset release, in_op=7'h03 pulse, out_ready=1 -> next cycle out_cw bit3 and bit25 set, out_last=1, out_beat=0; then IDLE.
REQ-033 in_op=7'h45 (R=2), out_ready=1 -> three beats out_beat 0,1,2, out_cw bits 5,25, out_last only on beat 2.
REQ-034 out_ready low 4 cycles during beat 1 of R=3 opcode -> outputs frozen, total beats still 4.
REQ-035 Back-to-back 7'h01,7'h02 with in_valid held -> beats on consecutive cycles, no idle gap, in_ready pulses on final-beat cycle.
REQ-036 With CTRL_SAT_LOOP_EN, in_op=7'h1F, sat=1 on beat 6 -> 7 beats, last beat 6; sat held 0 -> 15 beats, last beat 14.
REQ-037 rst_n low during beat 1 of R=3 opcode -> out_valid 0 immediately, IDLE with no further beats after release.
